// File: rtl/tetris_pkg.sv
// Shared types and helpers for the tetromino piece scheduler.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package tetris_pkg;

    typedef enum logic [2:0] {
        PIECE_T = 3'd0,
        PIECE_J = 3'd1,
        PIECE_Z = 3'd2,
        PIECE_O = 3'd3,
        PIECE_S = 3'd4,
        PIECE_L = 3'd5,
        PIECE_I = 3'd6
    } piece_t;

    localparam logic [2:0] PIECE_INVALID = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROLL1 = 2'd1,
        ROLL2 = 2'd2
    } sched_state_t;

    localparam logic [4:0] LFSR_SEED  = 5'h1F;
    localparam int         LFSR_STEPS = 5;

    // Advance the 5-bit Fibonacci register by one full clock's worth of shifts.
    function automatic logic [4:0] lfsr_adv(input logic [4:0] d);
        logic [4:0] v;
        v = d;
        for (int i = 0; i < LFSR_STEPS; i++) begin
            v = {v[4] ^ v[1], v[4:1]};
        end
        return v;
    endfunction

    // Reroll mapping: (r + base) folded back into 0..6, never the invalid code.
    function automatic piece_t piece_wrap_add(input logic [2:0] r, input piece_t base);
        logic [3:0] sum;
        sum = {1'b0, r} + {1'b0, base};
        if (sum >= 4'd7) begin
            sum = sum - 4'd7;
        end
        return piece_t'(sum[2:0]);
    endfunction

endpackage

// File: rtl/piece_lfsr5.sv
// Free-running 5-bit LFSR, five shifts per clock; exports the low 3 bits as raw piece candidates.
// Latency: new value every cycle; a load replaces that cycle's advance and is visible next cycle.
// Backpressure: none, never stalls; a zero load is replaced by the lockup-free seed.
module piece_lfsr5
    import tetris_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [4:0] load_val,
    output logic [2:0] rnd_bits
);

    logic [4:0] lfsr_q;

    // Shift register: load (with zero substitution) has priority over the free-running advance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_q <= LFSR_SEED;
        end else if (load) begin
            lfsr_q <= (load_val == 5'd0) ? LFSR_SEED : load_val;
        end else begin
            lfsr_q <= lfsr_adv(lfsr_q);
        end
    end

    assign rnd_bits = lfsr_q[2:0];

endmodule

// File: rtl/piece_scheduler.sv
// Generates tetromino codes with repeat/invalid reroll into a small queue with head and preview taps.
// Latency: accepted roll pushes in 1 cycle, reroll in 2; refill starts the cycle after a pop frees space.
// Backpressure: head is valid/ready; generation idles while the queue is full; flush empties and restarts.
module piece_scheduler
    import tetris_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             seed_we,
    input  logic [4:0]       seed_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_piece,
    output logic             preview_valid,
    output logic [2:0]       preview_piece,
    output logic [CNT_W-1:0] piece_count
);

    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int               OCC_W    = $clog2(DEPTH + 1);
    localparam logic [OCC_W-1:0] DEPTH_C  = OCC_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [2:0]       rnd;
    sched_state_t     state;
    sched_state_t     state_nxt;
    piece_t           last;
    piece_t           push_piece;
    piece_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;
    logic [OCC_W-1:0] occ_inc;
    logic             has_room;
    logic             push;
    logic             pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    piece_lfsr5 u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .load     (seed_we),
        .load_val (seed_in),
        .rnd_bits (rnd)
    );

    // A pop coinciding with flush is discarded: it neither advances the queue nor counts.
    assign pop      = out_valid & out_ready & ~flush;
    assign has_room = (occ < DEPTH_C);
    // Occupancy after a push this cycle, accounting for a simultaneous pop.
    assign occ_inc  = occ + OCC_W'(1) - OCC_W'(pop);

    // Roll FSM next state and push decision; flush aborts any roll and restarts at ROLL1.
    always_comb begin
        state_nxt  = state;
        push       = 1'b0;
        push_piece = last;
        case (state)
            IDLE: begin
                if (has_room) begin
                    state_nxt = ROLL1;
                end
            end
            ROLL1: begin
                if (!has_room) begin
                    state_nxt = IDLE;
                end else if ((rnd != PIECE_INVALID) && (rnd != last)) begin
                    push       = 1'b1;
                    push_piece = piece_t'(rnd);
                    state_nxt  = (occ_inc < DEPTH_C) ? ROLL1 : IDLE;
                end else begin
                    state_nxt = ROLL2;
                end
            end
            ROLL2: begin
                if (!has_room) begin
                    state_nxt = IDLE;
                end else begin
                    // Second roll is trusted outright: no repeat check here.
                    push       = 1'b1;
                    push_piece = piece_wrap_add(rnd, last);
                    state_nxt  = (occ_inc < DEPTH_C) ? ROLL1 : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (flush) begin
            state_nxt = ROLL1;
            push      = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Most recently generated piece; deliberately survives flush so a new game still avoids a repeat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last <= PIECE_T;
        end else if (push) begin
            last <= push_piece;
        end
    end

    // Circular buffer storage, pointers and occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= PIECE_T;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_piece;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            occ <= occ + OCC_W'(push) - OCC_W'(pop);
        end
    end

    // Saturating count of accepted pops, cleared by flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            piece_count <= '0;
        end else if (flush) begin
            piece_count <= '0;
        end else if (pop && (piece_count != '1)) begin
            piece_count <= piece_count + 1'b1;
        end
    end

    // Outputs come straight from occupancy and storage; out_ready never reaches out_valid.
    assign out_valid     = (occ != '0);
    assign out_piece     = out_valid ? mem[rd_ptr] : PIECE_T;
    assign preview_valid = (occ >= OCC_W'(2));
    assign preview_piece = preview_valid ? mem[ptr_inc(rd_ptr)] : PIECE_T;

endmodule

// File: tb/tb_piece_scheduler.sv
// Bench for piece_scheduler: hand-derived vector table, async reset mid-refill, then a
// randomized run against a queue-based reference model.
module tb_piece_scheduler;

    localparam int DEPTH   = 2;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int NROWS   = 22;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic             seed_we;
    logic [4:0]       seed_in;
    logic             out_ready;
    logic             out_valid;
    logic [2:0]       out_piece;
    logic             preview_valid;
    logic [2:0]       preview_piece;
    logic [CNT_W-1:0] piece_count;

    int n_checks = 0;
    int n_fail   = 0;

    piece_scheduler #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .seed_we       (seed_we),
        .seed_in       (seed_in),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_piece     (out_piece),
        .preview_valid (preview_valid),
        .preview_piece (preview_piece),
        .piece_count   (piece_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int fl; int sw; int sd; int rdy;
        int ev; int ep; int epv; int epp; int ec;
    } row_t;

    row_t rows [NROWS];

    // ---------------- reference model (queue + spec rules) ----------------
    int m_lfsr;
    int m_last;
    int m_phase;   // 0 waiting for space, 1 first roll, 2 second roll
    int m_cnt;
    int m_q [$];

    function automatic int adv5(input int d);
        int v;
        v = d;
        for (int i = 0; i < 5; i++) begin
            v = ((((v >> 4) ^ (v >> 1)) & 1) << 4) | (v >> 1);
        end
        return v;
    endfunction

    task automatic model_reset();
        m_lfsr  = 31;
        m_last  = 0;
        m_phase = 0;
        m_cnt   = 0;
        m_q.delete();
    endtask

    task automatic model_edge();
        int  nl;
        int  gen;
        int  c;
        bit  pop;
        pop = (m_q.size() > 0) && out_ready;
        nl  = seed_we ? ((seed_in == 0) ? 31 : int'(seed_in)) : adv5(m_lfsr);
        c   = m_lfsr % 8;
        if (flush) begin
            m_q.delete();
            m_cnt   = 0;
            m_phase = 1;
        end else begin
            gen = -1;
            if (m_phase == 0) begin
                if (m_q.size() < DEPTH) m_phase = 1;
            end else if (m_phase == 1) begin
                if (c != 7 && c != m_last) gen = c;
                else m_phase = 2;
            end else begin
                gen = (c + m_last) % 7;
            end
            if (pop) begin
                void'(m_q.pop_front());
                if (m_cnt < CNT_MAX) m_cnt++;
            end
            if (gen >= 0) begin
                m_q.push_back(gen);
                m_last  = gen;
                m_phase = (m_q.size() < DEPTH) ? 1 : 0;
            end
        end
        m_lfsr = nl;
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input int ev, input int ep,
                              input int epv, input int epp, input int ec);
        chk({tag, " out_valid"},     int'(out_valid),     ev);
        chk({tag, " out_piece"},     int'(out_piece),     ep);
        chk({tag, " preview_valid"}, int'(preview_valid), epv);
        chk({tag, " preview_piece"}, int'(preview_piece), epp);
        chk({tag, " piece_count"},   int'(piece_count),   ec);
    endtask

    task automatic check_model(input string tag);
        int sz;
        sz = m_q.size();
        check_outs(tag, (sz > 0) ? 1 : 0, (sz > 0) ? m_q[0] : 0,
                   (sz > 1) ? 1 : 0, (sz > 1) ? m_q[1] : 0, m_cnt);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        flush     = 1'b0;
        seed_we   = 1'b0;
        seed_in   = 5'd0;
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_outs("reset_hold", 0, 0, 0, 0, 0);
        reset = 1'b1;
        model_reset();
    endtask

    task automatic set_row(input int i, input int fl, input int sw, input int sd, input int rdy,
                           input int ev, input int ep, input int epv, input int epp, input int ec);
        rows[i] = '{fl, sw, sd, rdy, ev, ep, epv, epp, ec};
    endtask

    task automatic run_rows(input int lo, input int hi, input string tag);
        for (int i = lo; i <= hi; i++) begin
            flush     = rows[i].fl[0];
            seed_we   = rows[i].sw[0];
            seed_in   = rows[i].sd[4:0];
            out_ready = rows[i].rdy[0];
            tick();
            check_outs($sformatf("%s row%0d", tag, i),
                       rows[i].ev, rows[i].ep, rows[i].epv, rows[i].epp, rows[i].ec);
        end
        clear_inputs();
    endtask

    initial begin
        int hs;
        int bias;

        //            fl sw sd rdy | ev ep epv epp ec
        set_row( 0,   0, 0, 0, 0,    0, 0, 0, 0, 0);   // IDLE -> ROLL1
        set_row( 1,   0, 0, 0, 0,    1, 2, 0, 0, 0);   // Z from lfsr 1A
        set_row( 2,   0, 0, 0, 0,    1, 2, 1, 4, 0);   // S from lfsr 04, now full
        set_row( 3,   0, 0, 0, 0,    1, 2, 1, 4, 0);   // full: holds
        set_row( 4,   0, 0, 0, 1,    1, 4, 0, 0, 1);   // pop Z
        set_row( 5,   0, 0, 0, 0,    1, 4, 0, 0, 1);   // IDLE -> ROLL1
        set_row( 6,   0, 0, 0, 0,    1, 4, 1, 6, 1);   // accept I
        set_row( 7,   0, 0, 0, 1,    1, 6, 0, 0, 2);   // pop S
        set_row( 8,   0, 0, 0, 1,    0, 0, 0, 0, 3);   // pop I, empty
        set_row( 9,   0, 0, 0, 0,    0, 0, 0, 0, 3);   // candidate 6 == last: reroll
        set_row(10,   0, 0, 0, 0,    1, 1, 0, 0, 3);   // (2+6) mod 7 = J
        set_row(11,   0, 0, 0, 0,    1, 1, 1, 4, 3);   // accept S
        set_row(12,   1, 1, 0, 1,    0, 0, 0, 0, 0);   // flush + zero seed, pop dropped
        set_row(13,   0, 0, 0, 0,    0, 0, 0, 0, 0);   // candidate 7: reroll
        set_row(14,   0, 0, 0, 0,    1, 6, 0, 0, 0);   // (2+4) = I, last kept over flush
        set_row(15,   0, 0, 0, 0,    1, 6, 1, 4, 0);   // accept S
        set_row(16,   0, 0, 0, 1,    1, 4, 0, 0, 1);   // pop I
        set_row(17,   0, 0, 0, 0,    1, 4, 0, 0, 1);   // IDLE -> ROLL1
        set_row(18,   0, 0, 0, 0,    1, 4, 0, 0, 1);   // candidate 4 == last: into ROLL2
        set_row(19,   1, 0, 0, 1,    0, 0, 0, 0, 0);   // flush in ROLL2 with pop
        set_row(20,   0, 0, 0, 0,    1, 2, 0, 0, 0);   // refill from ROLL1
        set_row(21,   0, 0, 0, 0,    1, 2, 1, 4, 0);

        clear_inputs();
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", 0, 0, 0, 0, 0);
        reset = 1'b1;

        run_rows(0, NROWS - 1, "tbl");

        // Async reset asserted between edges while a refill is in flight.
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        #2;
        reset = 1'b0;
        #1;
        check_outs("async_reset", 0, 0, 0, 0, 0);
        #3;
        reset = 1'b1;
        model_reset();
        run_rows(0, 2, "post_reset");

        // Continuous out_ready: count handshakes independently of the DUT counter.
        do_reset();
        hs = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (out_valid) hs++;
            tick();
            check_model("cont");
        end
        chk("cont handshakes", int'(piece_count), (hs > CNT_MAX) ? CNT_MAX : hs);
        clear_inputs();

        // Randomized run against the model: reseeds (incl. zero), flushes, varying ready bias.
        do_reset();
        bias = 3;
        for (int i = 0; i < 30000; i++) begin
            if (i % 1000 == 0) bias = $urandom_range(1, 4);
            out_ready = ($urandom_range(0, 3) < bias);
            flush     = ($urandom_range(0, 299) == 0);
            seed_we   = ($urandom_range(0, 39) == 0);
            seed_in   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            tick();
            check_model("rand");
            if (out_valid) chk("rand no_code7", (out_piece == 3'd7) ? 1 : 0, 0);
        end
        clear_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
